// File: rtl/sa_feeder_if.sv
// sa_feeder_if: control, memory-read, array-drive and result-write signals of the systolic feeder
interface sa_feeder_if #(
    parameter int BN_NUM   = 4,
    parameter int ACCU_NUM = 2,
    parameter int BW_ACT   = 8,
    parameter int BW_WET   = 8,
    parameter int IA_H     = 8,
    parameter int IA_W     = 8,
    parameter int OA_W     = 8
);
    localparam int HW = $clog2(IA_H);
    localparam int WW = $clog2(IA_W);
    localparam int OW = $clog2(OA_W);

    logic                       start;
    logic [7:0]                 shift_num;
    logic                       busy;
    logic                       done;
    logic                       wet_rd_en;
    logic [WW-1:0]              wet_rd_row;
    logic [OW-1:0]              wet_rd_col;
    logic [BW_WET-1:0]          wet_rd_data;
    logic [ACCU_NUM-1:0]        act_rd_en;
    logic [ACCU_NUM*HW-1:0]     act_rd_row;
    logic [ACCU_NUM*WW-1:0]     act_rd_col;
    logic [ACCU_NUM*BW_ACT-1:0] act_rd_data;
    logic                       PE_mac_enable;
    logic                       PE_clear_acc;
    logic                       PE_weight_partial_sel;
    logic [BW_WET-1:0]          PE_wet_in;
    logic [ACCU_NUM*BW_ACT-1:0] PE_act_in;
    logic [7:0]                 PE_res_shift_num;
    logic [BN_NUM*BW_ACT-1:0]   PE_result_out;
    logic                       res_wr_en;
    logic [HW-1:0]              res_wr_row;
    logic [OW-1:0]              res_wr_col;
    logic [BN_NUM*BW_ACT-1:0]   res_wr_data;

    modport master (
        input  start, shift_num, wet_rd_data, act_rd_data, PE_result_out,
        output busy, done, wet_rd_en, wet_rd_row, wet_rd_col,
               act_rd_en, act_rd_row, act_rd_col,
               PE_mac_enable, PE_clear_acc, PE_weight_partial_sel,
               PE_wet_in, PE_act_in, PE_res_shift_num,
               res_wr_en, res_wr_row, res_wr_col, res_wr_data
    );

    modport slave (
        output start, shift_num, wet_rd_data, act_rd_data, PE_result_out,
        input  busy, done, wet_rd_en, wet_rd_row, wet_rd_col,
               act_rd_en, act_rd_row, act_rd_col,
               PE_mac_enable, PE_clear_acc, PE_weight_partial_sel,
               PE_wet_in, PE_act_in, PE_res_shift_num,
               res_wr_en, res_wr_row, res_wr_col, res_wr_data
    );
endinterface

// File: rtl/sa_feeder.sv
// sa_feeder: sequences weight loads, skewed activation feeds, drain, clear and result write per output tile
module sa_feeder #(
    parameter int BN_NUM    = 4,
    parameter int ACCU_NUM  = 2,
    parameter int BW_ACT    = 8,
    parameter int BW_WET    = 8,
    parameter int IA_H      = 8,
    parameter int IA_W      = 8,
    parameter int OA_W      = 8,
    parameter int DRAIN_CYC = 3
) (
    input logic         clk,
    input logic         reset_n,
    sa_feeder_if.master bus
);
    localparam int HW = $clog2(IA_H);
    localparam int WW = $clog2(IA_W);
    localparam int OW = $clog2(OA_W);
    localparam int JN = IA_H / BN_NUM;
    localparam int IN = IA_W / ACCU_NUM;
    localparam int JW = JN > 1 ? $clog2(JN) : 1;
    localparam int IW = IN > 1 ? $clog2(IN) : 1;
    localparam int CW = $clog2(BN_NUM + ACCU_NUM + DRAIN_CYC);

    typedef enum logic [2:0] {IDLE, WLOAD, FEED, DRAIN, CLEAR, WRITE} state_t;

    state_t                     state, next;
    logic [CW-1:0]              cnt;
    logic [IW-1:0]              i;
    logic [JW-1:0]              j;
    logic [OW-1:0]              m;
    logic                       cnt_last, last_i, last_j, last_m, last_tile, done, go;
    logic                       mac_q, clr_q, sel_q, wet_q;
    logic [7:0]                 shift_q;
    logic [ACCU_NUM-1:0]        lane_en, lane_q;
    logic [ACCU_NUM*HW-1:0]     lane_row;
    logic [ACCU_NUM*WW-1:0]     lane_col;
    logic [ACCU_NUM*BW_ACT-1:0] lane_act;

    assign cnt_last  = state == WLOAD ? cnt == CW'(ACCU_NUM - 1) :
                       state == FEED  ? cnt == CW'(BN_NUM + ACCU_NUM - 2) :
                                        cnt == CW'(DRAIN_CYC - 1);
    assign last_i    = i == IW'(IN - 1);
    assign last_j    = j == JW'(JN - 1);
    assign last_m    = m == OW'(OA_W - 1);
    assign last_tile = last_j && last_m;
    assign done      = state == WRITE && last_tile;
    assign go        = bus.start && (state == IDLE || done);

    // Lane g consumes activation rows skewed by g cycles; requests outside the skew window are masked.
    for (genvar g = 0; g < ACCU_NUM; g++) begin : g_lane
        assign lane_en[g] = state == FEED && int'(cnt) >= g && int'(cnt) - g < BN_NUM;
        assign lane_row[g*HW +: HW] = lane_en[g] ? HW'(int'(j) * BN_NUM + int'(cnt) - g) : '0;
        assign lane_col[g*WW +: WW] = lane_en[g] ? WW'(int'(i) * ACCU_NUM + g) : '0;
        assign lane_act[g*BW_ACT +: BW_ACT] = lane_q[g] ? bus.act_rd_data[g*BW_ACT +: BW_ACT] : '0;
    end

    // Next-state: WLOAD/FEED alternate over i, then drain, clear and write one tile.
    always_comb begin
        next = state;
        case (state)
            IDLE:    next = bus.start ? WLOAD : IDLE;
            WLOAD:   next = cnt_last ? FEED : WLOAD;
            FEED:    next = cnt_last ? (last_i ? DRAIN : WLOAD) : FEED;
            DRAIN:   next = cnt_last ? CLEAR : DRAIN;
            CLEAR:   next = WRITE;
            WRITE:   next = last_tile && !bus.start ? IDLE : WLOAD;
            default: next = IDLE;
        endcase
    end

    // State, tile counters and the control stage that lines up with the one-cycle memory latency.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            cnt     <= '0;
            i       <= '0;
            j       <= '0;
            m       <= '0;
            mac_q   <= 1'b0;
            clr_q   <= 1'b1;
            sel_q   <= 1'b1;
            wet_q   <= 1'b0;
            lane_q  <= '0;
            shift_q <= '0;
        end else begin
            state  <= next;
            cnt    <= next == state && state != IDLE ? cnt + CW'(1) : '0;
            if (state == FEED && cnt_last)
                i <= last_i ? '0 : i + IW'(1);
            if (state == WRITE) begin
                j <= last_j ? '0 : j + JW'(1);
                if (last_j)
                    m <= last_m ? '0 : m + OW'(1);
            end
            mac_q  <= next != IDLE;
            clr_q  <= state == IDLE || state == CLEAR || state == WRITE;
            sel_q  <= state != FEED;
            wet_q  <= bus.wet_rd_en;
            lane_q <= lane_en;
            if (go)
                shift_q <= bus.shift_num;
        end
    end

    assign bus.busy                  = mac_q;
    assign bus.done                  = done;
    assign bus.wet_rd_en             = state == WLOAD;
    assign bus.wet_rd_row            = state == WLOAD ? WW'(int'(i) * ACCU_NUM + ACCU_NUM - 1 - int'(cnt)) : '0;
    assign bus.wet_rd_col            = state == WLOAD ? m : '0;
    assign bus.act_rd_en             = lane_en;
    assign bus.act_rd_row            = lane_row;
    assign bus.act_rd_col            = lane_col;
    assign bus.PE_mac_enable         = mac_q;
    assign bus.PE_clear_acc          = clr_q;
    assign bus.PE_weight_partial_sel = sel_q;
    assign bus.PE_wet_in             = {BW_WET{wet_q}} & bus.wet_rd_data;
    assign bus.PE_act_in             = lane_act;
    assign bus.PE_res_shift_num      = shift_q;
    assign bus.res_wr_en             = state == WRITE;
    assign bus.res_wr_row            = state == WRITE ? HW'(int'(j) * BN_NUM) : '0;
    assign bus.res_wr_col            = state == WRITE ? m : '0;
    assign bus.res_wr_data           = bus.PE_result_out;
endmodule

// File: tb/tb_sa_feeder.sv
// tb_sa_feeder: directed checks of the feeder schedule, addressing, pass length and reset behaviour
module tb_sa_feeder;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   ndone = 0;
    int   done_cyc = 0;
    int   nwr = 0;

    sa_feeder_if bus();
    sa_feeder dut (.clk(clk), .reset_n(reset_n), .bus(bus));

    always #5 clk = ~clk;

    // Expected first FEED of tile (0,0,0): {en}, {row1,row0}, {col1,col0} per step, then returned lanes.
    logic [1:0]  fe_en  [5] = '{2'b01, 2'b11, 2'b11, 2'b11, 2'b10};
    logic [5:0]  fe_row [5] = '{6'o00, 6'o01, 6'o12, 6'o23, 6'o30};
    logic [5:0]  fe_col [5] = '{6'o00, 6'o10, 6'o10, 6'o10, 6'o10};
    logic [15:0] fe_act [5] = '{16'h0010, 16'h1120, 16'h2130, 16'h3140, 16'h4100};
    // WLOAD request cycles, weight rows (col 0) and the weights returned one cycle later.
    int          wl_cyc [4] = '{1, 2, 8, 9};
    logic [2:0]  wl_row [4] = '{3'd1, 3'd0, 3'd3, 3'd2};
    logic [7:0]  wl_in  [4] = '{8'h88, 8'h80, 8'h98, 8'h90};

    function automatic logic [7:0] wv(input logic [2:0] r, input logic [2:0] c);
        return {2'b10, r, c};
    endfunction

    function automatic logic [7:0] av(input logic [2:0] r, input logic [2:0] c);
        return {1'b0, r, 4'h0} + 8'h10 + {5'b0, c};
    endfunction

    // Synchronous weight and activation memories with one-cycle read latency.
    always @(posedge clk) begin
        bus.wet_rd_data <= wv(bus.wet_rd_row, bus.wet_rd_col);
        bus.act_rd_data <= {av(bus.act_rd_row[5:3], bus.act_rd_col[5:3]),
                            av(bus.act_rd_row[2:0], bus.act_rd_col[2:0])};
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_ctl"}, {bus.busy, bus.done, bus.wet_rd_en, bus.act_rd_en, bus.res_wr_en,
                            bus.PE_mac_enable, bus.PE_clear_acc, bus.PE_weight_partial_sel}, 9'b0_0000_0011);
        chk({tag, "_addr"}, {bus.wet_rd_row, bus.wet_rd_col, bus.act_rd_row, bus.act_rd_col,
                             bus.res_wr_row, bus.res_wr_col}, 24'h0);
        chk({tag, "_data"}, {bus.PE_wet_in, bus.PE_act_in, bus.PE_res_shift_num}, 32'h0);
    endtask

    initial begin
        int w;
        bus.start = 1'b0;
        bus.shift_num = 8'd0;
        bus.PE_result_out = '0;
        #12 chk_idle("reset");
        #10 reset_n = 1'b1;
        @(posedge clk); #1;
        chk_idle("idle");

        bus.shift_num = 8'd8;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int c = 1; c <= 540; c++) begin
            bus.start = c == 100;
            if (c == 50)
                bus.shift_num = 8'd2;
            bus.PE_result_out = 32'hC0DE_0000 | 32'(c);
            #1;
            if (bus.done) begin
                ndone++;
                done_cyc = c;
            end
            if (bus.res_wr_en) begin
                chk("wr_cyc", 64'(c), 64'(33 * nwr + 33));
                chk("wr_row", bus.res_wr_row, 64'((nwr % 2) * 4));
                chk("wr_col", bus.res_wr_col, 64'(nwr / 2));
                chk("wr_data", bus.res_wr_data, 32'hC0DE_0000 | 32'(c));
                nwr++;
            end
            for (int k = 0; k < 4; k++) begin
                if (c == wl_cyc[k])
                    chk("wl_rd", {bus.wet_rd_en, bus.wet_rd_row, bus.wet_rd_col}, {1'b1, wl_row[k], 3'd0});
                if (c == wl_cyc[k] + 1) begin
                    chk("wl_in", bus.PE_wet_in, wl_in[k]);
                    chk("wl_sel", bus.PE_weight_partial_sel, 1'b1);
                end
            end
            if (c >= 3 && c <= 7)
                chk("feed_rd", {bus.act_rd_en, bus.act_rd_row, bus.act_rd_col},
                    {fe_en[c-3], fe_row[c-3], fe_col[c-3]});
            if (c >= 4 && c <= 8) begin
                chk("feed_act", bus.PE_act_in, fe_act[c-4]);
                chk("feed_sel", bus.PE_weight_partial_sel, 1'b0);
            end
            case (c)
                1:   chk("busy_c1", {bus.busy, bus.PE_mac_enable, bus.done}, 3'b110);
                11:  chk("feed_wet", {bus.PE_weight_partial_sel, bus.PE_wet_in}, 9'h0);
                30:  chk("drain_rd", {bus.wet_rd_en, bus.act_rd_en}, 3'b000);
                31:  chk("drain_act", bus.PE_act_in, 16'h0);
                32:  chk("clr_c32", bus.PE_clear_acc, 1'b0);
                33:  chk("clr_c33", bus.PE_clear_acc, 1'b1);
                34:  chk("clr_c34", bus.PE_clear_acc, 1'b1);
                35:  chk("clr_c35", bus.PE_clear_acc, 1'b0);
                300: chk("shift_hold", bus.PE_res_shift_num, 8'd8);
                528: chk("busy_c528", {bus.busy, bus.PE_mac_enable}, 2'b11);
                529: chk("busy_c529", {bus.busy, bus.PE_mac_enable, bus.done}, 3'b000);
                default: ;
            endcase
            @(posedge clk); #1;
        end
        chk("done_cnt", 64'(ndone), 64'd1);
        chk("done_cyc", 64'(done_cyc), 64'd528);
        chk("wr_cnt", 64'(nwr), 64'd16);

        bus.shift_num = 8'h33;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (249) @(posedge clk);
        #1;
        chk("mid_busy", bus.busy, 1'b1);
        chk("mid_feed", {bus.act_rd_en, bus.act_rd_row, bus.act_rd_col}, {2'b11, 3'd5, 3'd6, 3'd5, 3'd4});
        #2 reset_n = 1'b0;
        #1 chk_idle("async_rst");
        repeat (3) begin
            @(posedge clk); #1;
            chk("rst_hold", {bus.res_wr_en, bus.done, bus.busy}, 3'b000);
        end
        reset_n = 1'b1;
        @(posedge clk); #1;
        bus.shift_num = 8'd5;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        w = 1;
        while (!bus.res_wr_en && w < 60) begin
            @(posedge clk); #1;
            w++;
        end
        chk("rst_wr_cyc", 64'(w), 64'd33);
        chk("rst_wr_addr", {bus.res_wr_en, bus.res_wr_row, bus.res_wr_col}, {1'b1, 6'd0});
        chk("rst_shift", bus.PE_res_shift_num, 8'd5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/sa_feeder.md
SA_FEEDER -- requirements
Module: sa_feeder

Interface
REQ-001 SHALL have parameters: BN_NUM 4 (PE rows/outputs); ACCU_NUM 2 (activation lanes); BW_ACT 8; BW_WET 8; IA_H 8, IA_W 8 (activation matrix); OA_W 8 (weight/output columns); DRAIN_CYC 3.
REQ-002 SHALL have ports, clock and reset first:
- clk  in  1  single clock; all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to run one full matrix pass.
- shift_num  in  8  result shift, latched at start.
- busy  out  1  pass in progress.
- done  out  1  one-cycle pulse at pass end.
- wet_rd_en, wet_rd_row, wet_rd_col  out  1/clog2(IA_W)/clog2(OA_W)  weight memory read request.
- wet_rd_data  in  BW_WET  read data; synchronous memory, valid 1 cycle after request.
- act_rd_en, act_rd_row, act_rd_col  out  ACCU_NUM / ACCU_NUM*clog2(IA_H) / ACCU_NUM*clog2(IA_W)  per-lane activation reads.
- act_rd_data  in  ACCU_NUM*BW_ACT  per-lane data, 1-cycle latency.
- PE_mac_enable, PE_clear_acc, PE_weight_partial_sel  out  1 each  array control.
- PE_wet_in  out  BW_WET  serial weight to array.
- PE_act_in  out  ACCU_NUM*BW_ACT  skewed activation lanes.
- PE_res_shift_num  out  8  result shift to array.
- PE_result_out  in  BN_NUM*BW_ACT  array results.
- res_wr_en, res_wr_row, res_wr_col, res_wr_data  out  1/clog2(IA_H)/clog2(OA_W)/BN_NUM*BW_ACT  result write: BN_NUM rows starting at res_wr_row, column res_wr_col.

Function
REQ-003 SHALL implement FSM IDLE, WLOAD, FEED, DRAIN, CLEAR, WRITE.
REQ-004 SHALL accept start only in IDLE; start while busy ignored.
REQ-005 SHALL iterate tiles m=0..OA_W-1 (outer), j=0..IA_H/BN_NUM-1, i=0..IA_W/ACCU_NUM-1 (inner).
REQ-006 WLOAD: ACCU_NUM cycles, step k reads weight row i*ACCU_NUM+ACCU_NUM-1-k, col m; PE_weight_partial_sel=1, PE_clear_acc=0.
REQ-007 FEED: BN_NUM+ACCU_NUM-1 cycles, step l=1..; lane idx reads row j*BN_NUM+l-idx-1, col i*ACCU_NUM+idx, only when 0<=l-idx-1<BN_NUM; else act_rd_en[idx]=0 and that PE_act_in lane SHALL be 0. PE_weight_partial_sel=0.
REQ-008 After FEED: next i → WLOAD; last i → DRAIN.
REQ-009 DRAIN: DRAIN_CYC cycles, no reads, PE_act_in=0.
REQ-010 CLEAR: 1 cycle, PE_clear_acc=1.
REQ-011 WRITE: 1 cycle; res_wr_en=1, res_wr_row=j*BN_NUM, res_wr_col=m, res_wr_data=PE_result_out that cycle; PE_clear_acc stays 1.
REQ-012 After WRITE: next (m,j) → WLOAD; last tile → IDLE with done=1 that cycle; start in that cycle is accepted.
REQ-013 Read requests SHALL issue one cycle ahead; PE_wet_in/PE_act_in pass through memory data; PE control outputs and lane-valid mask SHALL be registered one stage to align with returned data.
REQ-014 PE_mac_enable=1 whenever busy; busy=1 from the cycle after accepted start until done.
REQ-015 PE_res_shift_num SHALL hold shift_num latched at start for the whole pass.
REQ-016 Pass length (defaults): 16 tiles × (4×(2+5)+3+1+1) = 528 cycles from start to done.
REQ-017 Addresses SHALL never exceed IA_H-1/IA_W-1/OA_W-1; no wrap-around.

Reset
REQ-018 reset_n=0 SHALL immediately force IDLE, busy=0, done=0, all rd/wr enables 0, all addresses 0, PE_mac_enable=0, PE_clear_acc=1, PE_weight_partial_sel=1, PE_wet_in=0, PE_act_in=0, PE_res_shift_num=0.
REQ-019 Reset mid-pass SHALL abort with no done and no further res_wr_en; next start begins at tile (0,0,0).

Verification
REQ-020 Identity weights, A[r][c]=r+c, shift 0 → res_wr_data matches A per tile; done at cycle 528.
REQ-021 First FEED of tile (0,0,0): lane0 rows 0,1,2,3,-; lane1 rows -,0,1,2,3 (- = disabled, PE_act_in lane 0).
REQ-022 WLOAD tile (0,0,1): weight rows 3 then 2, col 0, PE_weight_partial_sel=1 two cycles.
REQ-023 start pulsed at cycle 100 of a pass → ignored; single done at 528.
REQ-024 reset_n low during FEED of tile (3,1,2) → all outputs at REQ-018 values same cycle; restart yields first write to row 0, col 0.
REQ-025 shift_num=8 at start, changed to 2 mid-pass → PE_res_shift_num stays 8.
